// File: rtl/wb_regfile.sv
// Write-back stage and architectural register file.
// Selects the write-back value from MEM/WB, commits it to a 32 x XLEN register file,
// serves two combinational ID read ports with write-through bypass, and counts retired writes.
module wb_regfile #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] read_data_in,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic [4:0]      rd_in,
  input  logic            reg_write_in,
  input  logic            mem_to_reg_in,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_valid,
  output logic [31:0]     wb_count
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [31:0]     wb_count_q;
  logic [31:0]     wb_count_d;

  // Write-back value select and effective-write qualifier (x0 writes and reset cycles dropped).
  always_comb begin
    wb_data  = mem_to_reg_in ? read_data_in : alu_result_in;
    wb_valid = reg_write_in & (rd_in != 5'd0) & ~rst;
  end

  // Register array: synchronous clear on reset, otherwise commit the effective write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_valid) begin
      regs_q[rd_in] <= wb_data;
    end
  end

  // Retired-write counter next state; wraps silently at 2^32.
  always_comb begin
    wb_count_d = wb_count_q + {31'd0, wb_valid};
  end

  // Retired-write counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_count_q <= '0;
    end else begin
      wb_count_q <= wb_count_d;
    end
  end

  assign wb_count = wb_count_q;

  // Read port 1: x0 hardwired to zero, in-flight write bypassed so ID sees it this cycle.
  always_comb begin
    rs1_data = '0;
    if (rst || rs1_addr == 5'd0) begin
      rs1_data = '0;
    end else if (wb_valid && rs1_addr == rd_in) begin
      rs1_data = wb_data;
    end else begin
      rs1_data = regs_q[rs1_addr];
    end
  end

  // Read port 2: same rules as port 1, bypassed independently.
  always_comb begin
    rs2_data = '0;
    if (rst || rs2_addr == 5'd0) begin
      rs2_data = '0;
    end else if (wb_valid && rs2_addr == rd_in) begin
      rs2_data = wb_data;
    end else begin
      rs2_data = regs_q[rs2_addr];
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: a behavioural model pushes expected outputs to a
// scoreboard queue as each cycle's stimulus is driven; they are popped and compared #1 later.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic [31:0] read_data_in;
  logic [31:0] alu_result_in;
  logic [4:0]  rd_in;
  logic        reg_write_in;
  logic        mem_to_reg_in;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] wb_data;
  logic        wb_valid;
  logic [31:0] wb_count;

  wb_regfile #(
    .XLEN(32),
    .NREG(32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .read_data_in (read_data_in),
    .alu_result_in(alu_result_in),
    .rd_in        (rd_in),
    .reg_write_in (reg_write_in),
    .mem_to_reg_in(mem_to_reg_in),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .wb_data      (wb_data),
    .wb_valid     (wb_valid),
    .wb_count     (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum logic [2:0] {OutRs1, OutRs2, OutWbData, OutWbValid, OutWbCount} out_e;
  typedef struct {
    string       tag;
    out_e        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp;
  int          n_err;
  logic [31:0] regs_m [32];
  logic [31:0] cnt_m;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic r, input logic v, input logic [4:0] rd,
                                             input logic [31:0] wd, input logic [4:0] a);
    if (r || a == 5'd0) return 32'd0;
    if (v && a == rd) return wd;
    return regs_m[a];
  endfunction

  task automatic push(input string tag, input out_e sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sel)
        OutRs1:     obs = rs1_data;
        OutRs2:     obs = rs2_data;
        OutWbData:  obs = wb_data;
        OutWbValid: obs = {31'd0, wb_valid};
        default:    obs = wb_count;
      endcase
      check_eq(e.tag, obs, e.exp);
    end
  endtask

  // One cycle: apply inputs at negedge, check combinational outputs, then clock and update model.
  task automatic drive(input string tag, input logic r, input logic rw, input logic m2r,
                       input logic [4:0] rd, input logic [31:0] ld, input logic [31:0] alu,
                       input logic [4:0] a1, input logic [4:0] a2);
    logic [31:0] wd;
    logic        v;
    @(negedge clk);
    rst           = r;
    reg_write_in  = rw;
    mem_to_reg_in = m2r;
    rd_in         = rd;
    read_data_in  = ld;
    alu_result_in = alu;
    rs1_addr      = a1;
    rs2_addr      = a2;
    wd = m2r ? ld : alu;
    v  = rw && (rd != 5'd0) && !r;
    push({tag, ".rs1"}, OutRs1, model_read(r, v, rd, wd, a1));
    push({tag, ".rs2"}, OutRs2, model_read(r, v, rd, wd, a2));
    push({tag, ".wbd"}, OutWbData, wd);
    push({tag, ".wbv"}, OutWbValid, {31'd0, v});
    if (!$isunknown(cnt_m)) push({tag, ".cnt"}, OutWbCount, cnt_m);
    #1;
    drain();
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) regs_m[i] = 32'd0;
      cnt_m = 32'd0;
    end else if (v) begin
      regs_m[rd] = wd;
      cnt_m      = cnt_m + 32'd1;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    cnt_m = 'x;
    for (int i = 0; i < 32; i++) regs_m[i] = 'x;
    rst = 1'b1; reg_write_in = 1'b0; mem_to_reg_in = 1'b0; rd_in = '0;
    read_data_in = '0; alu_result_in = '0; rs1_addr = '0; rs2_addr = '0;

    drive("rst0", 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd1, 5'd2);
    drive("rst1", 1'b1, 1'b1, 1'b0, 5'd3, 32'd0, 32'h77, 5'd3, 5'd0);

    // Preload every register; each write is read through bypass and the previous from the array.
    for (int i = 1; i < 32; i++) begin
      drive("pre", 1'b0, 1'b1, i[0], 5'(i), $urandom, $urandom, 5'(i), 5'(i - 1));
    end

    // Reset mid-stream with a pending write to x5: must be dropped and everything cleared.
    drive("rst_mid", 1'b1, 1'b1, 1'b0, 5'd5, 32'd0, 32'h1234_5678, 5'd5, 5'd5);
    for (int i = 0; i < 32; i += 2) begin
      drive("rst_rd", 1'b0, 1'b0, 1'b0, 5'd5, 32'd0, 32'd0, 5'(i), 5'(i + 1));
    end

    drive("alu", 1'b0, 1'b1, 1'b0, 5'd3, 32'hFFFF_0000, 32'h0000_1234, 5'd3, 5'd0);
    drive("alu_arr", 1'b0, 1'b0, 1'b0, 5'd3, 32'd0, 32'd0, 5'd3, 5'd3);
    drive("ld", 1'b0, 1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF, 32'h10, 5'd7, 5'd3);
    drive("ld_arr", 1'b0, 1'b0, 1'b0, 5'd7, 32'd0, 32'd0, 5'd0, 5'd7);
    drive("x0", 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    drive("pre4", 1'b0, 1'b1, 1'b0, 5'd4, 32'd0, 32'h99, 5'd0, 5'd0);
    drive("bubble", 1'b0, 1'b0, 1'b0, 5'd4, 32'd0, 32'h55, 5'd0, 5'd4);
    drive("bubble2", 1'b0, 1'b0, 1'b0, 5'd4, 32'd0, 32'h55, 5'd4, 5'd4);
    drive("dual", 1'b0, 1'b1, 1'b0, 5'd9, 32'd0, 32'hA5A5_A5A5, 5'd9, 5'd9);
    drive("dual_arr", 1'b0, 1'b0, 1'b1, 5'd9, 32'h1, 32'h2, 5'd9, 5'd9);

    for (int i = 0; i < 60; i++) begin
      drive("rand", 1'b0, 1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom,
            5'($urandom), 5'($urandom));
    end

    // Backdoor the counter to all-ones through its next-state net, then retire one more write.
    @(negedge clk);
    reg_write_in = 1'b0;
    force dut.wb_count_d = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.wb_count_d;
    cnt_m = 32'hFFFF_FFFF;
    drive("wrap", 1'b0, 1'b1, 1'b0, 5'd9, 32'd0, 32'h0BAD_F00D, 5'd9, 5'd1);
    drive("wrap0", 1'b0, 1'b0, 1'b0, 5'd9, 32'd0, 32'd0, 5'd9, 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
